stage_sequencer: RTL and testbench
==================================

// Module: stage_sequencer
// PURPOSE
//  Parametrised multicycle control sequencer for the ARM core: walks NUM_STAGES pipeline-register stages
//  (fetch, reg fetch, execute, data memory, writeback at default) one at a time, replacing the fixed
//  5-state loop. Adds per-stage wait states, stage skipping, condition-fail/flush early exit, halt,
//  stall timeout and retire/stall counters. stage_latch[] drives stage-register clock enables on clk;
//  stage registers are never clocked from a derived signal.
// PARAMETERS
//  NUM_STAGES   5    stages per instruction (min 2); stage 0 is fetch
//  COND_STAGE   1    stage whose completion samples cond_fail
//  WAIT_LIMIT   15   consecutive stall cycles in one stage before error; 0 disables
//  CNT_W        32   width of retired_count / stall_count
//  STAGE_W      $clog2(NUM_STAGES)  width of cur_stage (derived, not overridden)
// PORTS
//  clk            in   1           core clock
//  nreset         in   1           synchronous reset, active low
//  run            in   1           level: permit execution from IDLE
//  halt_req       in   1           level: stop at next instruction boundary
//  stage_ready    in   NUM_STAGES  stage s finished its work this cycle (hold low = wait state)
//  stage_skip     in   NUM_STAGES  skip stage s for current instruction; bit 0 ignored
//  cond_fail      in   1           condition test failed; valid on completion of COND_STAGE
//  flush          in   1           abort rest of instruction (taken branch); valid on any completion
//  stage_go       out  NUM_STAGES  one-hot, high for every cycle spent in stage s
//  stage_latch    out  NUM_STAGES  one-cycle pulse: stage s completes (stage_go & stage_ready)
//  cur_stage      out  STAGE_W     index of active stage; 0 when not RUN
//  retire         out  1           pulse: instruction ended (normal or early)
//  squashed       out  1           pulse with retire when ended by cond_fail/flush
//  halted         out  1           in IDLE
//  error          out  1           in ERROR (stall timeout), sticky until reset
//  retired_count  out  CNT_W       retire pulses since reset, wraps modulo 2^CNT_W
//  stall_count    out  CNT_W       RUN cycles with active stage_ready low, wraps
// BEHAVIOUR
//  - Reset (nreset=0 at posedge): state IDLE, cur_stage 0, counters 0, wait counter 0, error 0;
//    stage_go/stage_latch/retire/squashed 0, halted 1. Overrides everything, including mid-instruction.
//  - States IDLE, RUN, ERROR. IDLE->RUN(stage 0) when run=1 and halt_req=0; halt_req wins over run.
//  - RUN, stage s, stage_ready[s]=0: stay; wait counter +1, stall_count +1. Counter reaching
//    WAIT_LIMIT (and WAIT_LIMIT!=0) -> ERROR next edge; all go/latch outputs 0 in ERROR.
//  - RUN, stage_ready[s]=1: stage_latch[s]=1 this cycle; wait counter cleared; next stage by priority:
//    1 flush -> end instruction, squashed=1
//    2 s==COND_STAGE and cond_fail -> end instruction, squashed=1
//    3 lowest t>s with stage_skip[t]=0 -> stage t
//    4 no such t -> end instruction, squashed=0
//  - End of instruction: retire=1 same cycle, retired_count +1 at that edge; next state IDLE if
//    halt_req=1 or run=0, else stage 0. Skip bits sampled only at completion of previous stage.
//  - stage_latch, retire, squashed combinational from registered state + inputs; all else registered.
//  - Latency: NUM_STAGES cycles per instruction with all ready=1, no skip; back-to-back, no bubble.
//  - Skip-all case: skip[1..N-1]=1 gives 1-cycle instructions (fetch only).
// STRUCTURE
//  - Shared package cpu_seq_pkg: state encoding (SEQ_IDLE/SEQ_RUN/SEQ_ERROR), default stage indices
//    (STG_FETCH=0, STG_REG=1, STG_EXEC=2, STG_MEM=3, STG_WB=4).
//  - One sub-module stage_next_sel: combinational priority pick of next stage / end flag from s, skip
//    vector, flush, cond_fail. Sequencer holds state, counters, output decode.
// TESTING
//  - Reset, run=1, all ready=1, no skip: stage_go 00001,00010,..,10000 repeating; retire every 5th cycle;
//    retired_count=4 after 20 cycles.
//  - stage_ready[3] low 3 cycles: stay in stage 3 for 4 cycles, stall_count=3, instruction 8 cycles.
//  - stage_skip=5'b01000 (no mem): sequence 0,1,2,4; retire every 4 cycles.
//  - cond_fail=1 at stage 1 completion: next stage 0, retire=1, squashed=1; flush at stage 2 likewise.
//  - halt_req raised mid stage 2: instruction finishes, halted=1 next cycle; drop halt_req -> stage 0.
//  - WAIT_LIMIT=15, ready[2] held low: error=1 after 15 stall cycles, outputs 0; nreset=0 in stage 3
//    of a later run -> IDLE, counters 0 next edge.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the multicycle stage sequencer: FSM state encoding,
// default pipeline stage indices and a width helper for the stall timer.
package cpu_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_ERROR = 2'd2
    } seq_state_t;

    localparam int STG_FETCH = 0;
    localparam int STG_REG   = 1;
    localparam int STG_EXEC  = 2;
    localparam int STG_MEM   = 3;
    localparam int STG_WB    = 4;

    // Width of a counter that must be able to hold the value 'limit'.
    function automatic int wait_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/stage_next_sel.sv
// Combinational next-stage picker for the stage sequencer. Given the stage that
// is completing this cycle, decides whether the instruction ends (and whether
// that end is a squash) or which stage comes next.
module stage_next_sel
    import cpu_seq_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int COND_STAGE = 1,
    parameter int STAGE_W    = $clog2(NUM_STAGES)
) (
    input  logic [STAGE_W-1:0]    i_stage,
    input  logic [NUM_STAGES-1:0] i_skip,
    input  logic                  i_flush,
    input  logic                  i_cond_fail,
    output logic [STAGE_W-1:0]    o_next_stage,
    output logic                  o_end,
    output logic                  o_squash
);

    logic               w_found;
    logic [STAGE_W-1:0] w_cand;

    // Priority: flush, then condition failure at the condition stage, then the
    // lowest later non-skipped stage; running off the end retires normally.
    // The scan runs high-to-low so the lowest qualifying stage is written last.
    // Stage 0 can never qualify because it is never later than the current stage.
    always_comb begin
        w_found      = 1'b0;
        w_cand       = '0;
        o_next_stage = '0;
        o_end        = 1'b0;
        o_squash     = 1'b0;

        for (int t = NUM_STAGES - 1; t >= 0; t--) begin
            if ((t > int'(i_stage)) && !i_skip[t]) begin
                w_found = 1'b1;
                w_cand  = STAGE_W'(t);
            end
        end

        if (i_flush) begin
            o_end    = 1'b1;
            o_squash = 1'b1;
        end else if ((int'(i_stage) == COND_STAGE) && i_cond_fail) begin
            o_end    = 1'b1;
            o_squash = 1'b1;
        end else if (w_found) begin
            o_next_stage = w_cand;
        end else begin
            o_end = 1'b1;
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle control sequencer: walks the instruction through NUM_STAGES
// pipeline stages one at a time, with per-stage wait states, stage skipping,
// squash on condition failure or flush, halt at instruction boundaries, a stall
// timeout and retire/stall counters. stage_latch is meant to be used as a clock
// enable for stage registers on clk.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  SEQ_IDLE  | not executing; waiting for run=1 with halt_req=0
//  SEQ_RUN   | executing stage r_stage of the current instruction
//  SEQ_ERROR | a stage stalled WAIT_LIMIT cycles; held until reset
module stage_sequencer
    import cpu_seq_pkg::*;
#(
    parameter  int NUM_STAGES = 5,
    parameter  int COND_STAGE = 1,
    parameter  int WAIT_LIMIT = 15,
    parameter  int CNT_W      = 32,
    localparam int STAGE_W    = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  run,
    input  logic                  halt_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    input  logic [NUM_STAGES-1:0] stage_skip,
    input  logic                  cond_fail,
    input  logic                  flush,
    output logic [NUM_STAGES-1:0] stage_go,
    output logic [NUM_STAGES-1:0] stage_latch,
    output logic [STAGE_W-1:0]    cur_stage,
    output logic                  retire,
    output logic                  squashed,
    output logic                  halted,
    output logic                  error,
    output logic [CNT_W-1:0]      retired_count,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int WAIT_W = wait_width(WAIT_LIMIT);

    seq_state_t            r_state;
    logic [STAGE_W-1:0]    r_stage;
    logic [NUM_STAGES-1:0] r_stage_go;
    logic                  r_halted;
    logic                  r_error;
    logic [WAIT_W-1:0]     r_wait;
    logic [CNT_W-1:0]      r_retired;
    logic [CNT_W-1:0]      r_stalls;

    logic                  w_active;
    logic                  w_ready;
    logic                  w_done;
    logic [STAGE_W-1:0]    w_next_stage;
    logic                  w_end;
    logic                  w_squash;
    logic [WAIT_W-1:0]     w_wait_inc;
    logic                  w_timeout;
    logic                  w_go_idle;

    assign w_active   = (r_state == SEQ_RUN);
    assign w_ready    = stage_ready[r_stage];
    assign w_done     = w_active & w_ready;
    assign w_wait_inc = r_wait + WAIT_W'(1);
    assign w_timeout  = (WAIT_LIMIT != 0) && (w_wait_inc == WAIT_W'(WAIT_LIMIT));
    assign w_go_idle  = halt_req | ~run;

    stage_next_sel #(
        .NUM_STAGES (NUM_STAGES),
        .COND_STAGE (COND_STAGE),
        .STAGE_W    (STAGE_W)
    ) u_next_sel (
        .i_stage      (r_stage),
        .i_skip       (stage_skip),
        .i_flush      (flush),
        .i_cond_fail  (cond_fail),
        .o_next_stage (w_next_stage),
        .o_end        (w_end),
        .o_squash     (w_squash)
    );

    // Sequencer FSM: state, active stage, stall timer and counters. The one-hot
    // stage_go is registered alongside r_stage so it never glitches.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state    <= SEQ_IDLE;
            r_stage    <= '0;
            r_stage_go <= '0;
            r_halted   <= 1'b1;
            r_error    <= 1'b0;
            r_wait     <= '0;
            r_retired  <= '0;
            r_stalls   <= '0;
        end else begin
            case (r_state)
                SEQ_IDLE: begin
                    if (run && !halt_req) begin
                        r_state    <= SEQ_RUN;
                        r_stage    <= STAGE_W'(STG_FETCH);
                        r_stage_go <= NUM_STAGES'(1) << STG_FETCH;
                        r_halted   <= 1'b0;
                    end
                end

                SEQ_RUN: begin
                    if (w_ready) begin
                        r_wait <= '0;
                        if (w_end) begin
                            r_retired <= r_retired + CNT_W'(1);
                            if (w_go_idle) begin
                                r_state    <= SEQ_IDLE;
                                r_stage    <= '0;
                                r_stage_go <= '0;
                                r_halted   <= 1'b1;
                            end else begin
                                r_stage    <= STAGE_W'(STG_FETCH);
                                r_stage_go <= NUM_STAGES'(1) << STG_FETCH;
                            end
                        end else begin
                            r_stage    <= w_next_stage;
                            r_stage_go <= NUM_STAGES'(1) << w_next_stage;
                        end
                    end else begin
                        r_wait   <= w_wait_inc;
                        r_stalls <= r_stalls + CNT_W'(1);
                        if (w_timeout) begin
                            r_state    <= SEQ_ERROR;
                            r_stage    <= '0;
                            r_stage_go <= '0;
                            r_error    <= 1'b1;
                        end
                    end
                end

                SEQ_ERROR: begin
                    r_state <= SEQ_ERROR;
                end

                default: begin
                    r_state    <= SEQ_IDLE;
                    r_stage    <= '0;
                    r_stage_go <= '0;
                    r_halted   <= 1'b1;
                end
            endcase
        end
    end

    assign stage_go      = r_stage_go;
    assign stage_latch   = r_stage_go & stage_ready;
    assign cur_stage     = r_stage;
    assign retire        = w_done & w_end;
    assign squashed      = w_done & w_end & w_squash;
    assign halted        = r_halted;
    assign error         = r_error;
    assign retired_count = r_retired;
    assign stall_count   = r_stalls;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer at default parameters. A cycle model
// derived from the sequencing rules is compared against every output on each
// falling edge; directed scenarios add hand-computed literal expectations.
module tb_stage_sequencer;

    logic        clk = 1'b0;
    logic        nreset;
    logic        run;
    logic        halt_req;
    logic [4:0]  stage_ready;
    logic [4:0]  stage_skip;
    logic        cond_fail;
    logic        flush;
    logic [4:0]  stage_go;
    logic [4:0]  stage_latch;
    logic [2:0]  cur_stage;
    logic        retire;
    logic        squashed;
    logic        halted;
    logic        error;
    logic [31:0] retired_count;
    logic [31:0] stall_count;

    stage_sequencer dut (
        .clk           (clk),
        .nreset        (nreset),
        .run           (run),
        .halt_req      (halt_req),
        .stage_ready   (stage_ready),
        .stage_skip    (stage_skip),
        .cond_fail     (cond_fail),
        .flush         (flush),
        .stage_go      (stage_go),
        .stage_latch   (stage_latch),
        .cur_stage     (cur_stage),
        .retire        (retire),
        .squashed      (squashed),
        .halted        (halted),
        .error         (error),
        .retired_count (retired_count),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model state: 0 idle, 1 running, 2 error
    int          m_mode  = 0;
    int          m_stage = 0;
    int          m_wait  = 0;
    logic [31:0] m_ret   = 0;
    logic [31:0] m_stall = 0;

    // Compare on the falling edge, then advance the model with the inputs that
    // the next rising edge will sample.
    always @(negedge clk) begin : model
        logic [4:0] e_go;
        logic [4:0] e_latch;
        bit         done;
        bit         fin;
        bit         sq;
        int         nxt;

        e_go = (m_mode == 1) ? 5'(1 << m_stage) : 5'd0;
        done = (m_mode == 1) && stage_ready[m_stage];
        fin  = 1'b0;
        sq   = 1'b0;
        nxt  = -1;
        if (done) begin
            if (flush) begin
                fin = 1'b1; sq = 1'b1;
            end else if (m_stage == 1 && cond_fail) begin
                fin = 1'b1; sq = 1'b1;
            end else begin
                for (int t = m_stage + 1; t < 5; t++)
                    if (nxt < 0 && !stage_skip[t]) nxt = t;
                if (nxt < 0) fin = 1'b1;
            end
        end
        e_latch = done ? e_go : 5'd0;

        if (chk_en) begin
            chk("stage_go",      stage_go,      e_go);
            chk("stage_latch",   stage_latch,   e_latch);
            chk("cur_stage",     cur_stage,     (m_mode == 1) ? m_stage : 0);
            chk("retire",        retire,        fin);
            chk("squashed",      squashed,      sq);
            chk("halted",        halted,        m_mode == 0);
            chk("error",         error,         m_mode == 2);
            chk("retired_count", retired_count, m_ret);
            chk("stall_count",   stall_count,   m_stall);
        end

        if (!nreset) begin
            m_mode = 0; m_stage = 0; m_wait = 0; m_ret = 0; m_stall = 0;
        end else if (m_mode == 0) begin
            if (run && !halt_req) begin m_mode = 1; m_stage = 0; end
        end else if (m_mode == 1) begin
            if (done) begin
                m_wait = 0;
                if (fin) begin
                    m_ret++;
                    if (halt_req || !run) m_mode = 0;
                    m_stage = 0;
                end else begin
                    m_stage = nxt;
                end
            end else begin
                m_stall++;
                m_wait++;
                if (m_wait == 15) begin m_mode = 2; m_stage = 0; end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        nreset = 1'b0; run = 1'b0; halt_req = 1'b0; stage_ready = 5'b11111;
        stage_skip = 5'b00000; cond_fail = 1'b0; flush = 1'b0;
        step(2);
        chk_en = 1'b1;
        chk("rst_halted",  halted,        1);
        chk("rst_go",      stage_go,      0);
        chk("rst_retired", retired_count, 0);

        // Straight-line execution, back to back
        nreset = 1'b1; run = 1'b1;
        step(1);
        chk("run_first_go", stage_go, 5'b00001);
        step(2);
        chk("run_go_s2", stage_go, 5'b00100);
        step(18);
        chk("run_retired4", retired_count, 4);
        chk("run_back_go",  stage_go,      5'b00001);

        // Wait states in stage 3
        step(3);
        stage_ready = 5'b10111;
        step(3);
        chk("stall_hold_go", stage_go,    5'b01000);
        chk("stall_count3",  stall_count, 3);
        stage_ready = 5'b11111;
        step(2);
        chk("stall_retired5", retired_count, 5);
        chk("stall_back_go",  stage_go,      5'b00001);

        // Skip memory stage: 0,1,2,4
        stage_skip = 5'b01000;
        step(3);
        chk("skip_go_wb", stage_go, 5'b10000);
        step(1);
        chk("skip_retired6", retired_count, 6);
        step(4);
        chk("skip_retired7", retired_count, 7);
        stage_skip = 5'b00000;

        // Condition fail at stage 1
        step(1);
        cond_fail = 1'b1;
        #1;
        chk("cond_retire",   retire,   1);
        chk("cond_squashed", squashed, 1);
        step(1);
        cond_fail = 1'b0;
        chk("cond_go",      stage_go,      5'b00001);
        chk("cond_retired", retired_count, 8);

        // Flush at stage 2
        step(2);
        flush = 1'b1;
        #1;
        chk("flush_retire",   retire,   1);
        chk("flush_squashed", squashed, 1);
        step(1);
        flush = 1'b0;
        chk("flush_go",      stage_go,      5'b00001);
        chk("flush_retired", retired_count, 9);

        // Halt requested mid stage 2
        step(2);
        halt_req = 1'b1;
        step(2);
        chk("halt_not_yet", halted, 0);
        step(1);
        chk("halt_halted",  halted,        1);
        chk("halt_retired", retired_count, 10);
        step(2);
        chk("halt_stays", halted, 1);
        halt_req = 1'b0;
        step(1);
        chk("halt_resume_go", stage_go, 5'b00001);

        // Stall timeout in stage 2
        step(2);
        stage_ready = 5'b11011;
        step(14);
        chk("to_not_yet", error, 0);
        step(1);
        chk("to_error", error,       1);
        chk("to_go",    stage_go,    0);
        chk("to_stall", stall_count, 18);
        step(3);
        chk("to_sticky", error, 1);

        // Recover by reset, then reset again mid stage 3
        nreset = 1'b0;
        step(1);
        nreset = 1'b1; stage_ready = 5'b11111;
        step(6);
        chk("rr_retired1", retired_count, 1);
        step(3);
        chk("rr_go_s3", stage_go, 5'b01000);
        nreset = 1'b0;
        step(1);
        chk("rr_halted",  halted,        1);
        chk("rr_retired", retired_count, 0);
        chk("rr_cur",     cur_stage,     0);

        // Skip all but fetch: one-cycle instructions
        nreset = 1'b1; stage_skip = 5'b11110;
        step(1);
        chk("fetch_only_go", stage_go, 5'b00001);
        chk("fetch_only_retire", retire, 1);
        step(5);
        chk("fetch_only_retired5", retired_count, 5);
        stage_skip = 5'b00000;

        // Mixed random traffic, model-checked every cycle
        for (int i = 0; i < 400; i++) begin
            nreset   = (i % 100 != 99);
            run      = ($urandom_range(9) != 0);
            halt_req = ($urandom_range(19) == 0);
            for (int b = 0; b < 5; b++) begin
                stage_ready[b] = ($urandom_range(6) != 0);
                stage_skip[b]  = ($urandom_range(2) == 0);
            end
            cond_fail = ($urandom_range(4) == 0);
            flush     = ($urandom_range(9) == 0);
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
